microcode_sequencer: RTL and testbench

- Parametrised microcoded instruction sequencer for the 8-bit-class CPU datapath.
- Fetches instruction words over the shared data bus, steps a microinstruction counter, and emits a packed control vector to the PC, memory, A/B registers and ALU.
- Over the previous decoder it adds:
  - data width parametrised by DATA_W;
  - an EXT prefix that supplies a full-width operand;
  - synchronous reset;
  - a sticky halt state;
  - concurrent instr_end, so no idle step;
  - an optional CALL/RET return stack.

---
 rtl/microcode_sequencer.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_microcode_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// ============================================================================
// Module   : microcode_sequencer
// Brief    : Microcoded fetch/execute sequencer emitting the CPU control vector.
//            Optional CALL/RET return stack enabled by defining MSEQ_CALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module microcode_sequencer #(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              flag_carry,
    input  logic              flag_zero,
    output logic [14:0]       ctrl,
    output logic [2:0]        step,
    output logic              halted,
    output logic              stack_err
);

    localparam int ARG_W = DATA_W - 4;

    localparam int c_PC_READ   = 0;
    localparam int c_PC_WRITE  = 1;
    localparam int c_PC_INC    = 2;
    localparam int c_MEM_WADDR = 3;
    localparam int c_MEM_READ  = 4;
    localparam int c_MEM_WRITE = 5;
    localparam int c_A_READ    = 6;
    localparam int c_A_WRITE   = 7;
    localparam int c_B_READ    = 8;
    localparam int c_B_WRITE   = 9;
    localparam int c_ALU_READ  = 10;
    localparam int c_ALU_SUB   = 11;
    localparam int c_ALU_FLAGS = 12;
    localparam int c_INSTR_WR  = 13;
    localparam int c_INSTR_END = 14;

    localparam logic [3:0] c_OP_NOP = 4'h0;
    localparam logic [3:0] c_OP_LDA = 4'h1;
    localparam logic [3:0] c_OP_LDB = 4'h2;
    localparam logic [3:0] c_OP_STA = 4'h3;
    localparam logic [3:0] c_OP_STB = 4'h4;
    localparam logic [3:0] c_OP_LIA = 4'h5;
    localparam logic [3:0] c_OP_LIB = 4'h6;
    localparam logic [3:0] c_OP_ADD = 4'h7;
    localparam logic [3:0] c_OP_SUB = 4'h8;
    localparam logic [3:0] c_OP_TST = 4'h9;
    localparam logic [3:0] c_OP_JMP = 4'hA;
    localparam logic [3:0] c_OP_BRC = 4'hB;
    localparam logic [3:0] c_OP_BRZ = 4'hC;
    localparam logic [3:0] c_OP_EXT = 4'hD;
    localparam logic [3:0] c_OP_CAL = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    logic [3:0]        r_op_q,        r_op_d;
    logic [ARG_W-1:0]  r_arg_q,       r_arg_d;
    logic [2:0]        r_step_q,      r_step_d;
    logic [DATA_W-1:0] r_ext_arg_q,   r_ext_arg_d;
    logic              r_ext_valid_q, r_ext_valid_d;
    logic              r_halted_q,    r_halted_d;

    logic [14:0]       w_ctrl;
    logic              w_bus_oe;
    logic [DATA_W-1:0] w_bus_out;
    logic              w_use_opnd;
    logic [DATA_W-1:0] w_opnd;

    assign w_opnd = r_ext_valid_q ? r_ext_arg_q : {4'b0000, r_arg_q};

`ifdef MSEQ_CALL_EN
    localparam int c_SP_W = $clog2(STACK_DEPTH);

    logic [DATA_W-1:0] r_stack_q [STACK_DEPTH];
    logic [c_SP_W:0]   r_sp_q,        r_sp_d;
    logic              r_stack_err_q, r_stack_err_d;
    logic [c_SP_W:0]   w_sp_m1;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_sp_m1 = r_sp_q - (c_SP_W + 1)'(1);
    assign w_full  = (r_sp_q == (c_SP_W + 1)'(STACK_DEPTH));
    assign w_empty = (r_sp_q == '0);
`endif

    always_comb begin
        w_ctrl        = '0;
        w_bus_oe      = 1'b0;
        w_bus_out     = '0;
        w_use_opnd    = 1'b0;
        r_op_d        = r_op_q;
        r_arg_d       = r_arg_q;
        r_step_d      = r_step_q + 3'd1;
        r_ext_arg_d   = r_ext_arg_q;
        r_ext_valid_d = r_ext_valid_q;
        r_halted_d    = r_halted_q;
`ifdef MSEQ_CALL_EN
        w_push        = 1'b0;
        w_pop         = 1'b0;
`endif
        if (r_halted_q) begin
            r_step_d = r_step_q;
        end else begin
            case (r_step_q)
                3'd0: begin
                    w_ctrl[c_PC_READ]   = 1'b1;
                    w_ctrl[c_MEM_WADDR] = 1'b1;
                end
                3'd1: begin
                    w_ctrl[c_MEM_READ] = 1'b1;
                    w_ctrl[c_INSTR_WR] = 1'b1;
                    w_ctrl[c_PC_INC]   = 1'b1;
                    {r_op_d, r_arg_d}  = bus_in;
                end
                3'd2: begin
                    case (r_op_q)
                        c_OP_NOP: begin
                            w_ctrl[c_INSTR_END] = 1'b1;
`ifdef MSEQ_CALL_EN
                            // RET: an empty stack returns address 0
                            if (r_arg_q == '1) begin
                                w_ctrl[c_PC_WRITE] = 1'b1;
                                w_bus_oe           = 1'b1;
                                w_bus_out          = w_empty ? '0 : r_stack_q[w_sp_m1[c_SP_W-1:0]];
                                w_pop              = 1'b1;
                            end
`endif
                        end
                        c_OP_LDA, c_OP_LDB, c_OP_STA, c_OP_STB: begin
                            w_ctrl[c_MEM_WADDR] = 1'b1;
                            w_use_opnd          = 1'b1;
                        end
                        c_OP_LIA: begin
                            w_ctrl[c_A_WRITE]   = 1'b1;
                            w_ctrl[c_INSTR_END] = 1'b1;
                            w_use_opnd          = 1'b1;
                        end
                        c_OP_LIB: begin
                            w_ctrl[c_B_WRITE]   = 1'b1;
                            w_ctrl[c_INSTR_END] = 1'b1;
                            w_use_opnd          = 1'b1;
                        end
                        c_OP_ADD, c_OP_SUB: begin
                            w_ctrl[c_ALU_READ]  = 1'b1;
                            w_ctrl[c_ALU_FLAGS] = 1'b1;
                            w_ctrl[c_A_WRITE]   = 1'b1;
                            w_ctrl[c_ALU_SUB]   = (r_op_q == c_OP_SUB);
                            w_ctrl[c_INSTR_END] = 1'b1;
                        end
                        c_OP_TST: begin
                            w_ctrl[c_ALU_SUB]   = 1'b1;
                            w_ctrl[c_ALU_FLAGS] = 1'b1;
                            w_ctrl[c_INSTR_END] = 1'b1;
                        end
                        c_OP_JMP, c_OP_BRC, c_OP_BRZ: begin
                            w_ctrl[c_INSTR_END] = 1'b1;
                            if ((r_op_q == c_OP_JMP) ||
                                (r_op_q == c_OP_BRC && flag_carry) ||
                                (r_op_q == c_OP_BRZ && flag_zero)) begin
                                w_ctrl[c_PC_WRITE] = 1'b1;
                                w_use_opnd         = 1'b1;
                            end
                        end
                        c_OP_EXT: begin
                            w_ctrl[c_PC_READ]   = 1'b1;
                            w_ctrl[c_MEM_WADDR] = 1'b1;
                        end
                        c_OP_CAL: begin
`ifdef MSEQ_CALL_EN
                            // bus carries the already-incremented PC here
                            w_ctrl[c_PC_READ] = 1'b1;
                            w_push            = 1'b1;
`else
                            w_ctrl[c_INSTR_END] = 1'b1;
`endif
                        end
                        default: begin
                            r_halted_d = 1'b1;
                            r_step_d   = r_step_q;
                        end
                    endcase
                end
                default: begin
                    w_ctrl[c_INSTR_END] = 1'b1;
                    case (r_op_q)
                        c_OP_LDA, c_OP_LDB: begin
                            w_ctrl[c_MEM_READ] = 1'b1;
                            w_ctrl[c_A_WRITE]  = (r_op_q == c_OP_LDA);
                            w_ctrl[c_B_WRITE]  = (r_op_q == c_OP_LDB);
                        end
                        c_OP_STA, c_OP_STB: begin
                            w_ctrl[c_MEM_WRITE] = 1'b1;
                            w_ctrl[c_A_READ]    = (r_op_q == c_OP_STA);
                            w_ctrl[c_B_READ]    = (r_op_q == c_OP_STB);
                        end
                        c_OP_EXT: begin
                            w_ctrl[c_MEM_READ] = 1'b1;
                            w_ctrl[c_PC_INC]   = 1'b1;
                            r_ext_arg_d        = bus_in;
                            r_ext_valid_d      = 1'b1;
                        end
`ifdef MSEQ_CALL_EN
                        c_OP_CAL: begin
                            w_ctrl[c_PC_WRITE] = 1'b1;
                            w_use_opnd         = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            endcase
        end

        if (w_ctrl[c_INSTR_END]) begin
            r_step_d = 3'd0;
            if (r_op_q != c_OP_EXT) begin
                r_ext_valid_d = 1'b0;
            end
        end

        if (w_use_opnd) begin
            w_bus_oe  = 1'b1;
            w_bus_out = w_opnd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op_q        <= '0;
            r_arg_q       <= '0;
            r_step_q      <= '0;
            r_ext_arg_q   <= '0;
            r_ext_valid_q <= 1'b0;
            r_halted_q    <= 1'b0;
        end else begin
            r_op_q        <= r_op_d;
            r_arg_q       <= r_arg_d;
            r_step_q      <= r_step_d;
            r_ext_arg_q   <= r_ext_arg_d;
            r_ext_valid_q <= r_ext_valid_d;
            r_halted_q    <= r_halted_d;
        end
    end

`ifdef MSEQ_CALL_EN
    always_comb begin
        r_sp_d        = r_sp_q;
        r_stack_err_d = r_stack_err_q;
        if (w_push) begin
            if (w_full) r_stack_err_d = 1'b1;
            else        r_sp_d        = r_sp_q + (c_SP_W + 1)'(1);
        end
        if (w_pop) begin
            if (w_empty) r_stack_err_d = 1'b1;
            else         r_sp_d        = w_sp_m1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sp_q        <= '0;
            r_stack_err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack_q[i] <= '0;
            end
        end else begin
            r_sp_q        <= r_sp_d;
            r_stack_err_q <= r_stack_err_d;
            if (w_push && !w_full) begin
                r_stack_q[r_sp_q[c_SP_W-1:0]] <= bus_in;
            end
        end
    end

    assign stack_err = r_stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

    assign ctrl    = reset ? '0 : w_ctrl;
    assign bus_oe  = reset ? 1'b0 : w_bus_oe;
    assign bus_out = reset ? '0 : w_bus_out;
    assign step    = r_step_q;
    assign halted  = r_halted_q;

endmodule

`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
// ============================================================================
// Module   : tb_microcode_sequencer
// Brief    : Directed scoreboard bench for microcode_sequencer (DATA_W = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_microcode_sequencer;

    localparam int DATA_W = 8;

    localparam logic [14:0] PCR  = 15'h0001;
    localparam logic [14:0] PCW  = 15'h0002;
    localparam logic [14:0] PCI  = 15'h0004;
    localparam logic [14:0] MWA  = 15'h0008;
    localparam logic [14:0] MRD  = 15'h0010;
    localparam logic [14:0] MWR  = 15'h0020;
    localparam logic [14:0] AR   = 15'h0040;
    localparam logic [14:0] AW   = 15'h0080;
    localparam logic [14:0] BR   = 15'h0100;
    localparam logic [14:0] BW   = 15'h0200;
    localparam logic [14:0] ALR  = 15'h0400;
    localparam logic [14:0] ASUB = 15'h0800;
    localparam logic [14:0] ASF  = 15'h1000;
    localparam logic [14:0] IW   = 15'h2000;
    localparam logic [14:0] IE   = 15'h4000;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] bus_in = '0;
    logic              flag_carry = 1'b0;
    logic              flag_zero = 1'b0;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [14:0]       ctrl;
    logic [2:0]        step;
    logic              halted;
    logic              stack_err;

    microcode_sequencer #(.DATA_W(DATA_W), .STACK_DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .ctrl       (ctrl),
        .step       (step),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [14:0]       ctrl;
        logic              oe;
        logic [DATA_W-1:0] out;
        logic [2:0]        step;
        logic              halted;
        logic              serr;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic  serr_exp = 1'b0;

    task automatic check(input string tag, input string field, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, expv);
        end
    endtask

    // Scoreboard: each directed step pushes one expectation, popped mid-cycle.
    always @(negedge clock) begin
        exp_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, "ctrl",      {17'd0, ctrl},      {17'd0, e.ctrl});
            check(t, "bus_oe",    {31'd0, bus_oe},    {31'd0, e.oe});
            if (e.oe) check(t, "bus_out", {24'd0, bus_out}, {24'd0, e.out});
            check(t, "step",      {29'd0, step},      {29'd0, e.step});
            check(t, "halted",    {31'd0, halted},    {31'd0, e.halted});
            check(t, "stack_err", {31'd0, stack_err}, {31'd0, e.serr});
        end
    end

    task automatic stp(input string tag, input logic [7:0] b, input logic [14:0] c,
                       input logic oe, input logic [7:0] o, input logic [2:0] s, input logic h);
        exp_t e;
        bus_in   = b;
        e.ctrl   = c;
        e.oe     = oe;
        e.out    = o;
        e.step   = s;
        e.halted = h;
        e.serr   = serr_exp;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [7:0] word);
        stp({tag, "_s0"}, 8'h00, PCR | MWA, 1'b0, 8'h00, 3'd0, 1'b0);
        stp({tag, "_s1"}, word, MRD | IW | PCI, 1'b0, 8'h00, 3'd1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        stp("rst", 8'hFF, 15'd0, 1'b0, 8'h00, 3'd0, 1'b0);
        reset = 1'b0;

        fetch("lia5a", 8'h5A);
        stp("lia5a_s2", 8'h00, AW | IE, 1'b1, 8'h0A, 3'd2, 1'b0);

        fetch("lda13", 8'h13);
        stp("lda13_s2", 8'h00, MWA, 1'b1, 8'h03, 3'd2, 1'b0);
        stp("lda13_s3", 8'h77, MRD | AW | IE, 1'b0, 8'h00, 3'd3, 1'b0);

        fetch("ldb2c", 8'h2C);
        stp("ldb2c_s2", 8'h00, MWA, 1'b1, 8'h0C, 3'd2, 1'b0);
        stp("ldb2c_s3", 8'h11, MRD | BW | IE, 1'b0, 8'h00, 3'd3, 1'b0);

        fetch("sta34", 8'h34);
        stp("sta34_s2", 8'h00, MWA, 1'b1, 8'h04, 3'd2, 1'b0);
        stp("sta34_s3", 8'h00, AR | MWR | IE, 1'b0, 8'h00, 3'd3, 1'b0);

        fetch("stb4f", 8'h4F);
        stp("stb4f_s2", 8'h00, MWA, 1'b1, 8'h0F, 3'd2, 1'b0);
        stp("stb4f_s3", 8'h00, BR | MWR | IE, 1'b0, 8'h00, 3'd3, 1'b0);

        fetch("sub", 8'h80);
        stp("sub_s2", 8'h00, ALR | ASF | AW | ASUB | IE, 1'b0, 8'h00, 3'd2, 1'b0);
        fetch("tst", 8'h90);
        stp("tst_s2", 8'h00, ASUB | ASF | IE, 1'b0, 8'h00, 3'd2, 1'b0);

        // EXT prefix feeding JMP, then cleared for the next LIA
        fetch("ext", 8'hD0);
        stp("ext_s2", 8'h00, PCR | MWA, 1'b0, 8'h00, 3'd2, 1'b0);
        stp("ext_s3", 8'hC8, MRD | PCI | IE, 1'b0, 8'h00, 3'd3, 1'b0);
        fetch("jmp", 8'hA2);
        stp("jmp_s2", 8'h00, PCW | IE, 1'b1, 8'hC8, 3'd2, 1'b0);
        fetch("lia51", 8'h51);
        stp("lia51_s2", 8'h00, AW | IE, 1'b1, 8'h01, 3'd2, 1'b0);

        // EXT then EXT: second overwrites; EXT then ADD discards the prefix
        fetch("ext1", 8'hD0);
        stp("ext1_s2", 8'h00, PCR | MWA, 1'b0, 8'h00, 3'd2, 1'b0);
        stp("ext1_s3", 8'h99, MRD | PCI | IE, 1'b0, 8'h00, 3'd3, 1'b0);
        fetch("ext2", 8'hD0);
        stp("ext2_s2", 8'h00, PCR | MWA, 1'b0, 8'h00, 3'd2, 1'b0);
        stp("ext2_s3", 8'hE4, MRD | PCI | IE, 1'b0, 8'h00, 3'd3, 1'b0);
        fetch("lib6x", 8'h61);
        stp("lib6x_s2", 8'h00, BW | IE, 1'b1, 8'hE4, 3'd2, 1'b0);
        fetch("ext3", 8'hD0);
        stp("ext3_s2", 8'h00, PCR | MWA, 1'b0, 8'h00, 3'd2, 1'b0);
        stp("ext3_s3", 8'hC8, MRD | PCI | IE, 1'b0, 8'h00, 3'd3, 1'b0);
        fetch("add", 8'h70);
        stp("add_s2", 8'h00, ALR | ASF | AW | IE, 1'b0, 8'h00, 3'd2, 1'b0);
        fetch("lib63", 8'h63);
        stp("lib63_s2", 8'h00, BW | IE, 1'b1, 8'h03, 3'd2, 1'b0);

        // Branches: flags matter only in step 2
        flag_zero = 1'b0;
        fetch("brz_nt", 8'hC7);
        stp("brz_nt_s2", 8'h00, IE, 1'b0, 8'h00, 3'd2, 1'b0);
        flag_zero = 1'b1;
        fetch("brz_t", 8'hC7);
        stp("brz_t_s2", 8'h00, PCW | IE, 1'b1, 8'h07, 3'd2, 1'b0);
        flag_zero  = 1'b0;
        flag_carry = 1'b1;
        fetch("brc_nt", 8'hB3);
        flag_carry = 1'b0;
        stp("brc_nt_s2", 8'h00, IE, 1'b0, 8'h00, 3'd2, 1'b0);
        fetch("brc_t", 8'hB3);
        flag_carry = 1'b1;
        stp("brc_t_s2", 8'h00, PCW | IE, 1'b1, 8'h03, 3'd2, 1'b0);
        flag_carry = 1'b0;

`ifdef MSEQ_CALL_EN
        for (int k = 1; k <= 5; k++) begin
            fetch($sformatf("call%0d", k), 8'hE0 | 8'(k));
            stp($sformatf("call%0d_s2", k), 8'h10 | 8'(k), PCR, 1'b0, 8'h00, 3'd2, 1'b0);
            if (k == 5) serr_exp = 1'b1;
            stp($sformatf("call%0d_s3", k), 8'h00, PCW | IE, 1'b1, 8'(k), 3'd3, 1'b0);
        end
        for (int k = 4; k >= 0; k--) begin
            fetch($sformatf("ret%0d", k), 8'h0F);
            stp($sformatf("ret%0d_s2", k), 8'h00, PCW | IE, 1'b1,
                (k == 0) ? 8'h00 : (8'h10 | 8'(k)), 3'd2, 1'b0);
        end
`else
        fetch("opE", 8'hE5);
        stp("opE_s2", 8'h22, IE, 1'b0, 8'h00, 3'd2, 1'b0);
        fetch("op0F", 8'h0F);
        stp("op0F_s2", 8'h00, IE, 1'b0, 8'h00, 3'd2, 1'b0);
`endif

        fetch("hlt", 8'hF0);
        stp("hlt_s2", 8'h00, 15'd0, 1'b0, 8'h00, 3'd2, 1'b0);
        flag_carry = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stp($sformatf("halt%0d", i), 8'h5A, 15'd0, 1'b0, 8'h00, 3'd2, 1'b1);
        end
        flag_carry = 1'b0;
        reset = 1'b1;
        stp("rst_halt", 8'h00, 15'd0, 1'b0, 8'h00, 3'd2, 1'b1);
        serr_exp = 1'b0;
        reset = 1'b0;

        fetch("lda_ab", 8'h13);
        stp("lda_ab_s2", 8'h00, MWA, 1'b1, 8'h03, 3'd2, 1'b0);
        reset = 1'b1;
        stp("lda_ab_s3", 8'h77, 15'd0, 1'b0, 8'h00, 3'd3, 1'b0);
        reset = 1'b0;
        stp("restart_s0", 8'h00, PCR | MWA, 1'b0, 8'h00, 3'd0, 1'b0);
        stp("restart_s1", 8'h69, MRD | IW | PCI, 1'b0, 8'h00, 3'd1, 1'b0);
        stp("restart_s2", 8'h00, BW | IE, 1'b1, 8'h09, 3'd2, 1'b0);
        stp("restart_nx", 8'h00, PCR | MWA, 1'b0, 8'h00, 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
